// File: rtl/inst_fetch_issuer.sv
// Purpose : fetches 16-bit instructions at the current PC and issues each one to
//           the interpreter as inst plus a 1-cycle start pulse, then waits for done.
// Latency : at least 4 cycles per instruction (FETCH, WAIT_MEM, ISSUE, EXEC).
// Backpressure: the interpreter throttles via done; a missing done for TIMEOUT cycles -> sticky error.
//
// Ports: clk/rst_n (sync, active-low); run level enable; prog_addr/prog_rd/prog_data
//        program memory (data valid the cycle after prog_rd); inst/start to the
//        interpreter, done/PC back from it; busy/halted/error status; issued count.
// Optional: define SINGLE_STEP_EN to add a 'step' input that gates each fetch on a
//           step rising edge (STEP_WAIT state between instructions).
module inst_fetch_issuer #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter logic [3:0] HALT_OPCODE = 4'hF,
    parameter int         TIMEOUT     = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
`ifdef SINGLE_STEP_EN
    input  logic        step,
`endif
    output logic [7:0]  prog_addr,
    output logic        prog_rd,
    input  logic [15:0] prog_data,
    output logic [15:0] inst,
    output logic        start,
    input  logic        done,
    input  logic [7:0]  PC,
    output logic        busy,
    output logic        halted,
    output logic        error,
    output logic [15:0] issued
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_WAIT_MEM  = 3'd2;
    localparam logic [2:0] S_ISSUE     = 3'd3;
    localparam logic [2:0] S_EXEC      = 3'd4;
    localparam logic [2:0] S_HALTED    = 3'd5;
    localparam logic [2:0] S_ERROR     = 3'd6;
    localparam logic [2:0] S_STEP_WAIT = 3'd7;

    // The counter starts at 0 on the first EXEC cycle; the error is taken when the
    // incremented value would reach TIMEOUT-1, i.e. TIMEOUT cycles after start.
    localparam int             TW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 2);

    logic [2:0]    state;
    logic [7:0]    pc;
    logic [TW-1:0] tmo_cnt;
    logic          done_q;
    logic          done_rise;

    assign done_rise = done & ~done_q;

`ifdef SINGLE_STEP_EN
    logic step_q;
    logic step_rise;
    assign step_rise = step & ~step_q;

    always_ff @(posedge clk) begin
        if (!rst_n) step_q <= 1'b0;
        else        step_q <= step;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            pc      <= RESET_PC;
            inst    <= 16'h0000;
            issued  <= 16'h0000;
            tmo_cnt <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= done;
            case (state)
                S_IDLE: begin
`ifdef SINGLE_STEP_EN
                    if (run && step_rise) state <= S_FETCH;
`else
                    if (run) state <= S_FETCH;
`endif
                end
                S_FETCH: state <= S_WAIT_MEM;
                S_WAIT_MEM: begin
                    // HALT is never issued and leaves inst untouched.
                    if (prog_data[15:12] == HALT_OPCODE) begin
                        state <= S_HALTED;
                    end else begin
                        inst  <= prog_data;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (issued != 16'hFFFF) issued <= issued + 16'd1;
                    tmo_cnt <= '0;
                    state   <= S_EXEC;
                end
                S_EXEC: begin
                    // done wins over a timeout landing on the same cycle.
                    if (done_rise) begin
                        pc <= PC;
                        if (run) begin
`ifdef SINGLE_STEP_EN
                            state <= S_STEP_WAIT;
`else
                            state <= S_FETCH;
`endif
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        state <= S_ERROR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
`ifdef SINGLE_STEP_EN
                S_STEP_WAIT: begin
                    if (!run)          state <= S_IDLE;
                    else if (step_rise) state <= S_FETCH;
                end
`endif
                S_HALTED: state <= S_HALTED;
                S_ERROR:  state <= S_ERROR;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // prog_addr tracks pc, which is only rewritten from the interpreter's PC on done.
    assign prog_addr = pc;
    assign prog_rd   = (state == S_FETCH);
    assign start     = (state == S_ISSUE);
    assign busy      = (state == S_FETCH) || (state == S_WAIT_MEM) ||
                       (state == S_ISSUE) || (state == S_EXEC);
    assign halted    = (state == S_HALTED);
    assign error     = (state == S_ERROR);

endmodule

// File: tb/tb_inst_fetch_issuer.sv
module tb_inst_fetch_issuer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        step;
    logic [7:0]  prog_addr;
    logic        prog_rd;
    logic [15:0] prog_data;
    logic [15:0] inst;
    logic        start;
    logic        done;
    logic [7:0]  PC;
    logic        busy;
    logic        halted;
    logic        error;
    logic [15:0] issued;

    always #5 clk = ~clk;

    inst_fetch_issuer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
`ifdef SINGLE_STEP_EN
        .step      (step),
`endif
        .prog_addr (prog_addr),
        .prog_rd   (prog_rd),
        .prog_data (prog_data),
        .inst      (inst),
        .start     (start),
        .done      (done),
        .PC        (PC),
        .busy      (busy),
        .halted    (halted),
        .error     (error),
        .issued    (issued)
    );

    // Program memory: registered read, data valid the cycle after prog_rd.
    logic [15:0] rom [0:255];
    always @(posedge clk) begin
        if (prog_rd) prog_data <= rom[prog_addr];
    end

    // Interpreter model. mode 0: 1-cycle done 3 cycles after start;
    // mode 1: never done; mode 2: done stays high once raised. kick forces done high.
    int   mode;
    logic kick;
    int   dly;
    always @(posedge clk) begin
        if (!rst_n) begin
            done <= 1'b0;
            dly  <= 0;
            PC   <= 8'h00;
        end else begin
            if (start) begin
                dly <= 2;
                PC  <= prog_addr + 8'd1;
            end else if (dly != 0) begin
                dly <= dly - 1;
            end
            if (kick)                              done <= 1'b1;
            else if (dly == 1 && !start && mode != 1) done <= 1'b1;
            else if (mode == 0 && done)            done <= 1'b0;
        end
    end

    // Logs of issued instructions and fetch addresses (cleared by reset).
    int          nstart;
    int          nfetch;
    logic [15:0] st_inst [0:7];
    logic [7:0]  f_addr  [0:7];
    always @(posedge clk) begin
        if (!rst_n) begin
            nstart = 0;
            nfetch = 0;
        end else begin
            if (start) begin
                if (nstart < 8) st_inst[nstart] = inst;
                nstart = nstart + 1;
            end
            if (prog_rd) begin
                if (nfetch < 8) f_addr[nfetch] = prog_addr;
                nfetch = nfetch + 1;
            end
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run   = 1'b0;
        step  = 1'b0;
        kick  = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_prog_addr"}, prog_addr, 8'h00);
        check({pfx, "_start"},     start,     1'b0);
        check({pfx, "_inst"},      inst,      16'h0000);
        check({pfx, "_busy"},      busy,      1'b0);
        check({pfx, "_issued"},    issued,    16'h0000);
        check({pfx, "_halted"},    halted,    1'b0);
        check({pfx, "_error"},     error,     1'b0);
        check({pfx, "_prog_rd"},   prog_rd,   1'b0);
    endtask

    initial begin
        int k;
        mode = 0;
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;

        // 1: reset values
        do_reset();
        check_reset_outputs("t1");

        // 2: two instructions then HALT
        rom[0] = 16'h0401; rom[1] = 16'h0C01; rom[2] = 16'hF000;
        mode = 0;
        rst_n = 1'b1; run = 1'b1;
        for (int i = 0; i < 100 && !halted; i++) @(negedge clk);
        check("t2_halted",  halted, 1'b1);
        check("t2_error",   error,  1'b0);
        check("t2_busy",    busy,   1'b0);
        check("t2_issued",  issued, 16'd2);
        check("t2_inst0",   st_inst[0], 16'h0401);
        check("t2_inst1",   st_inst[1], 16'h0C01);
        check("t2_nfetch",  nfetch, 3);
        check("t2_faddr0",  f_addr[0], 8'h00);
        check("t2_faddr1",  f_addr[1], 8'h01);
        check("t2_faddr2",  f_addr[2], 8'h02);
        check("t2_inst_kept", inst, 16'h0C01);
        repeat (10) @(negedge clk);
        check("t2_nstart",  nstart, 2);
        check("t2_halt_sticky", halted, 1'b1);

        // 3: done never comes -> error 64 cycles after start
        do_reset();
        rom[0] = 16'h0401; rom[1] = 16'h0000; rom[2] = 16'h0000;
        mode = 1;
        rst_n = 1'b1; run = 1'b1;
        for (int i = 0; i < 20 && !start; i++) @(negedge clk);
        check("t3_start_seen", start, 1'b1);
        k = 0;
        for (int i = 0; i < 100 && !error; i++) begin
            @(negedge clk);
            k++;
            if (!error) check("t3_busy_exec", busy, 1'b1);
        end
        check("t3_tmo_cycles", k, 64);
        check("t3_error", error, 1'b1);
        check("t3_busy",  busy,  1'b0);
        repeat (5) @(negedge clk);
        check("t3_nstart", nstart, 1);
        check("t3_start",  start,  1'b0);
        check("t3_error_sticky", error, 1'b1);

        // 4: run dropped during EXEC -> completes, parks in IDLE at new pc
        do_reset();
        rom[0] = 16'h4000; rom[1] = 16'h0401; rom[2] = 16'hF000;
        mode = 0;
        rst_n = 1'b1; run = 1'b1;
        for (int i = 0; i < 20 && !start; i++) @(negedge clk);
        check("t4_start_seen", start, 1'b1);
        @(negedge clk);
        run = 1'b0;
        repeat (8) @(negedge clk);
        check("t4_busy",      busy,      1'b0);
        check("t4_prog_addr", prog_addr, 8'h01);
        check("t4_nstart",    nstart,    1);
        check("t4_inst",      inst,      16'h4000);
        check("t4_halted",    halted,    1'b0);
        run = 1'b1;
        for (int i = 0; i < 100 && !halted; i++) @(negedge clk);
        check("t4_halted_after", halted, 1'b1);
        check("t4_faddr1", f_addr[1], 8'h01);
        check("t4_issued", issued, 16'd2);

        // 5: done held high -> second instruction needs a fresh rising edge
        do_reset();
        rom[0] = 16'h0401; rom[1] = 16'h0C01; rom[2] = 16'hF000;
        mode = 2;
        rst_n = 1'b1; run = 1'b1;
        for (int i = 0; i < 40 && nstart < 2; i++) @(negedge clk);
        check("t5_nstart2", nstart, 2);
        repeat (10) @(negedge clk);
        check("t5_done_high", done, 1'b1);
        check("t5_busy_wait", busy, 1'b1);
        check("t5_addr_wait", prog_addr, 8'h01);
        check("t5_nfetch",    nfetch, 2);
        mode = 0;
        repeat (2) @(negedge clk);
        kick = 1'b1;
        @(negedge clk);
        kick = 1'b0;
        for (int i = 0; i < 40 && !halted; i++) @(negedge clk);
        check("t5_halted",    halted,    1'b1);
        check("t5_error",     error,     1'b0);
        check("t5_prog_addr", prog_addr, 8'h02);
        check("t5_issued",    issued,    16'd2);

        // 5b: reset in the middle of EXEC
        do_reset();
        rom[0] = 16'h0401;
        mode = 1;
        rst_n = 1'b1; run = 1'b1;
        for (int i = 0; i < 20 && !start; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("t5b_busy_pre", busy, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("t5b");
        rst_n = 1'b1; run = 1'b0;
        @(negedge clk);

`ifdef SINGLE_STEP_EN
        // 6: one start per step pulse
        do_reset();
        rom[0] = 16'h0401; rom[1] = 16'h2801; rom[2] = 16'hF000;
        mode = 0;
        rst_n = 1'b1; run = 1'b1;
        repeat (6) @(negedge clk);
        check("t6_no_step", nstart, 0);
        for (int s = 1; s <= 3; s++) begin
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            repeat (10) @(negedge clk);
            check("t6_nstart", nstart, (s < 3) ? s : 2);
        end
        check("t6_halted", halted, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
